// File: rtl/l2_cache_ctrl.sv
// L2 request-side controller: tag/valid/dirty/LRU bookkeeping, data-array sequencing,
// and write-back/refill handshakes with main memory.
module l2_cache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 1024,
    parameter int WAYS   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cpu_req_valid_i,
    input  logic                     cpu_req_rw_i,
    input  logic [ADDR_W-1:0]        cpu_req_addr_i,
    input  logic [DATA_W-1:0]        cpu_req_data_i,
    output logic                     cpu_busy_o,
    output logic                     cpu_res_valid_o,
    output logic [DATA_W-1:0]        cpu_res_data_o,
    output logic                     mem_req_valid_o,
    output logic                     mem_req_rw_o,
    output logic [ADDR_W-1:0]        mem_req_addr_o,
    output logic [DATA_W-1:0]        mem_req_data_o,
    input  logic                     mem_res_ready_i,
    input  logic [DATA_W-1:0]        mem_res_data_i,
    output logic                     dar_we_o,
    output logic [$clog2(DEPTH)-1:0] dar_index_o,
    output logic [$clog2(WAYS)-1:0]  dar_way_o,
    output logic [DATA_W-1:0]        dar_wdata_o,
    input  logic [DATA_W-1:0]        dar_rdata_i
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - IDX_W - 4;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;
    state_t state, state_next;

    logic [TAG_W-1:0] tag_mem   [DEPTH][WAYS];
    logic [WAY_W-1:0] age_mem   [DEPTH][WAYS];
    logic [WAYS-1:0]  valid_mem [DEPTH];
    logic [WAYS-1:0]  dirty_mem [DEPTH];

    logic             req_rw;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_index;
    logic [DATA_W-1:0] req_data;
    logic [WAY_W-1:0] victim;

    logic [WAYS-1:0]  set_valid, set_dirty;
    logic             hit, victim_dirty, found_free;
    logic [WAY_W-1:0] hit_way, victim_sel;
    logic             addr_lsb_unused;

    assign addr_lsb_unused = ^cpu_req_addr_i[3:0];
    assign set_valid       = valid_mem[req_index];
    assign set_dirty       = dirty_mem[req_index];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (set_valid[w] && tag_mem[req_index][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest free way wins; only a full set falls back to the oldest way.
    always_comb begin
        victim_sel = '0;
        found_free = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!set_valid[w] && !found_free) begin
                victim_sel = WAY_W'(w);
                found_free = 1'b1;
            end
        end
        if (!found_free) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_mem[req_index][w] == WAY_W'(WAYS - 1)) victim_sel = WAY_W'(w);
            end
        end
        victim_dirty = set_valid[victim_sel] && set_dirty[victim_sel];
    end

    always_comb begin
        state_next      = state;
        cpu_busy_o      = (state != IDLE);
        mem_req_valid_o = 1'b0;
        mem_req_rw_o    = 1'b0;
        mem_req_addr_o  = '0;
        dar_we_o        = 1'b0;
        dar_index_o     = '0;
        dar_way_o       = '0;
        dar_wdata_o     = '0;
        case (state)
            IDLE: begin
                if (cpu_req_valid_i) state_next = COMPARE;
            end
            COMPARE: begin
                dar_index_o = req_index;
                if (hit) begin
                    dar_way_o = hit_way;
                    if (req_rw) begin
                        dar_we_o    = 1'b1;
                        dar_wdata_o = req_data;
                    end
                    state_next = IDLE;
                end else begin
                    dar_way_o  = victim_sel;
                    state_next = victim_dirty ? WRITE_BACK : ALLOCATE;
                end
            end
            WRITE_BACK: begin
                dar_index_o     = req_index;
                dar_way_o       = victim;
                mem_req_valid_o = 1'b1;
                mem_req_rw_o    = 1'b1;
                mem_req_addr_o  = {tag_mem[req_index][victim], req_index, 4'b0};
                if (mem_res_ready_i) state_next = ALLOCATE;
            end
            ALLOCATE: begin
                dar_index_o     = req_index;
                dar_way_o       = victim;
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = {req_tag, req_index, 4'b0};
                if (mem_res_ready_i) begin
                    dar_we_o    = 1'b1;
                    dar_wdata_o = mem_res_data_i;
                    state_next  = COMPARE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            req_rw          <= 1'b0;
            req_tag         <= '0;
            req_index       <= '0;
            req_data        <= '0;
            victim          <= '0;
            cpu_res_valid_o <= 1'b0;
            cpu_res_data_o  <= '0;
            mem_req_data_o  <= '0;
        end else begin
            state           <= state_next;
            cpu_res_valid_o <= 1'b0;
            if (state == IDLE && cpu_req_valid_i) begin
                req_rw    <= cpu_req_rw_i;
                req_tag   <= cpu_req_addr_i[ADDR_W-1:IDX_W+4];
                req_index <= cpu_req_addr_i[IDX_W+3:4];
                req_data  <= cpu_req_data_i;
            end
            if (state == COMPARE) begin
                if (hit) begin
                    cpu_res_valid_o <= 1'b1;
                    if (!req_rw) cpu_res_data_o <= dar_rdata_i;
                end else begin
                    victim <= victim_sel;
                    if (victim_dirty) mem_req_data_o <= dar_rdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) age_mem[s][w] <= WAY_W'(w);
            end
        end else begin
            case (state)
                COMPARE: begin
                    if (hit) begin
                        for (int unsigned w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == hit_way)
                                age_mem[req_index][w] <= '0;
                            else if (age_mem[req_index][w] < age_mem[req_index][hit_way])
                                age_mem[req_index][w] <= age_mem[req_index][w] + 1'b1;
                        end
                        if (req_rw) dirty_mem[req_index][hit_way] <= 1'b1;
                    end
                end
                WRITE_BACK: begin
                    if (mem_res_ready_i) dirty_mem[req_index][victim] <= 1'b0;
                end
                ALLOCATE: begin
                    if (mem_res_ready_i) begin
                        valid_mem[req_index][victim] <= 1'b1;
                        dirty_mem[req_index][victim] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && state == ALLOCATE && mem_res_ready_i) tag_mem[req_index][victim] <= req_tag;
    end
endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Scoreboard bench for l2_cache_ctrl: recency-list cache model, coherent golden memory,
// behavioural data array and a randomly-delayed main-memory responder.
module tb_l2_cache_ctrl;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 256;
    localparam int WAYS   = 4;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int TAG_W  = ADDR_W - IDX_W - 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req_valid = 1'b0, req_rw = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_data = '0;
    logic busy, res_valid, mreq_valid, mreq_rw, dar_we;
    logic [DATA_W-1:0] res_data, mreq_data, dar_wdata, dar_rdata;
    logic [ADDR_W-1:0] mreq_addr;
    logic mres_ready;
    logic [DATA_W-1:0] mres_data;
    logic [IDX_W-1:0] dar_index;
    logic [WAY_W-1:0] dar_way;

    l2_cache_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAYS(WAYS)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_valid_i(req_valid), .cpu_req_rw_i(req_rw),
        .cpu_req_addr_i(req_addr), .cpu_req_data_i(req_data),
        .cpu_busy_o(busy), .cpu_res_valid_o(res_valid), .cpu_res_data_o(res_data),
        .mem_req_valid_o(mreq_valid), .mem_req_rw_o(mreq_rw),
        .mem_req_addr_o(mreq_addr), .mem_req_data_o(mreq_data),
        .mem_res_ready_i(mres_ready), .mem_res_data_i(mres_data),
        .dar_we_o(dar_we), .dar_index_o(dar_index), .dar_way_o(dar_way),
        .dar_wdata_o(dar_wdata), .dar_rdata_i(dar_rdata)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] dar_mem [DEPTH][WAYS];
    assign dar_rdata = dar_mem[dar_index][dar_way];
    always @(posedge clk) if (dar_we) dar_mem[dar_index][dar_way] <= dar_wdata;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic              rw;
        logic              hit;
        logic [31:0]       cyc;
        logic [DATA_W-1:0] data;
    } resp_t;
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [WAY_W-1:0]  way;
        logic [IDX_W-1:0]  idx;
    } memx_t;

    resp_t exp_q[$];
    memx_t mq[$];
    int checks = 0, errors = 0;
    int unsigned issued = 0, resp_seen = 0, last_refill = 0;
    bit auto_mem = 1'b1;

    logic [TAG_W-1:0]  m_tag   [DEPTH][WAYS];
    bit                m_valid [DEPTH][WAYS];
    bit                m_dirty [DEPTH][WAYS];
    int unsigned       m_rec   [DEPTH][WAYS];  // ways, most recently used first
    logic [DATA_W-1:0] golden  [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] dram    [logic [ADDR_W-1:0]];

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endfunction

    function automatic logic [DATA_W-1:0] dram_read(input logic [ADDR_W-1:0] a);
        if (dram.exists(a)) return dram[a];
        return {a, ~a, a ^ 32'h5a5a_5a5a, 32'hc0de_0000 | {16'h0, a[15:0]}};
    endfunction

    function automatic logic [DATA_W-1:0] cpu_view(input logic [ADDR_W-1:0] a);
        if (golden.exists(a)) return golden[a];
        return dram_read(a);
    endfunction

    function automatic void model_reset();
        for (int unsigned s = 0; s < DEPTH; s++)
            for (int unsigned w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_rec[s][w]   = w;
            end
        golden.delete();
    endfunction

    function automatic void touch(input int unsigned s, input int unsigned w);
        int unsigned p = 0;
        for (int unsigned i = 0; i < WAYS; i++) if (m_rec[s][i] == w) p = i;
        for (int unsigned i = p; i > 0; i--) m_rec[s][i] = m_rec[s][i-1];
        m_rec[s][0] = w;
    endfunction

    function automatic void model_issue(input logic rw, input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] data);
        logic [ADDR_W-1:0] blk = {addr[ADDR_W-1:4], 4'b0};
        logic [IDX_W-1:0]  idx = addr[IDX_W+3:4];
        logic [TAG_W-1:0]  t   = addr[ADDR_W-1:IDX_W+4];
        int unsigned s = 32'(idx);
        int unsigned h = 0;
        bit hit = 1'b0, found = 1'b0;
        resp_t r;
        memx_t m;
        for (int unsigned w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) begin hit = 1'b1; h = w; end
        if (!hit) begin
            for (int unsigned w = 0; w < WAYS; w++)
                if (!m_valid[s][w] && !found) begin h = w; found = 1'b1; end
            if (!found) h = m_rec[s][WAYS-1];
            if (m_valid[s][h] && m_dirty[s][h]) begin
                m.rw = 1'b1; m.addr = {m_tag[s][h], idx, 4'b0};
                m.data = cpu_view(m.addr); m.way = WAY_W'(h); m.idx = idx;
                mq.push_back(m);
            end
            m.rw = 1'b0; m.addr = blk; m.data = '0; m.way = WAY_W'(h); m.idx = idx;
            mq.push_back(m);
            m_tag[s][h] = t; m_valid[s][h] = 1'b1; m_dirty[s][h] = 1'b0;
        end
        touch(s, h);
        if (rw) begin m_dirty[s][h] = 1'b1; golden[blk] = data; end
        r.rw = rw; r.hit = hit; r.cyc = cyc; r.data = cpu_view(blk);
        exp_q.push_back(r);
    endfunction

    resp_t mon_e;
    int unsigned mon_want;
    always @(negedge clk) begin
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_resp: got response data 0x%0h, expected no response", res_data);
            end else begin
                mon_e = exp_q.pop_front();
                mon_want = mon_e.hit ? mon_e.cyc + 2 : last_refill + 2;
                chk("resp_latency", 128'(cyc), 128'(mon_want));
                if (!mon_e.rw) chk("resp_data", res_data, mon_e.data);
                resp_seen++;
            end
        end
        if (dar_we) chk("dar_we_state", 128'(busy && !(mreq_valid && mreq_rw)), 128'(1));
    end

    initial begin
        memx_t m;
        int unsigned d;
        bit wb;
        mres_ready = 1'b0;
        mres_data  = '0;
        forever begin
            @(negedge clk);
            if (auto_mem && mreq_valid) begin
                wb = mreq_rw;
                if (mq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mem_req: got rw=%0d addr=0x%0h, expected none", mreq_rw, mreq_addr);
                    m.rw = mreq_rw; m.addr = mreq_addr; m.data = mreq_data; m.way = dar_way; m.idx = dar_index;
                end else begin
                    m = mq.pop_front();
                    chk("mem_rw", 128'(mreq_rw), 128'(m.rw));
                    chk("mem_addr", 128'(mreq_addr), 128'(m.addr));
                    if (m.rw) chk("wb_data", mreq_data, m.data);
                end
                if (wb) dram[mreq_addr] = mreq_data;
                d = $urandom_range(0, 3);
                repeat (d) @(negedge clk);
                mres_data  = wb ? {$urandom, $urandom, $urandom, $urandom} : dram_read(mreq_addr);
                mres_ready = 1'b1;
                #1;
                if (!wb) begin
                    last_refill = cyc;
                    chk("refill_we", 128'(dar_we), 128'(1));
                    chk("refill_way", 128'(dar_way), 128'(m.way));
                    chk("refill_index", 128'(dar_index), 128'(m.idx));
                    chk("refill_wdata", dar_wdata, mres_data);
                end
                @(negedge clk);
                mres_ready = 1'b0;
                if (wb) begin
                    chk("wb_alloc_valid", 128'(mreq_valid), 128'(1));
                    chk("wb_alloc_rw", 128'(mreq_rw), 128'(0));
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs", 128'(|{busy, res_valid, res_data, mreq_valid, mreq_rw, mreq_addr,
                                    mreq_data, dar_we, dar_index, dar_way, dar_wdata}), 128'(0));
        model_reset();
        exp_q.delete();
        mq.delete();
        resp_seen = issued;
    endtask

    task automatic issue(input logic rw, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data, input bit spurious);
        int unsigned n = 0;
        int unsigned target;
        while (busy && n < 100) begin @(negedge clk); n++; end
        model_issue(rw, addr, data);
        issued++;
        target = issued;
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_data = data;
        @(negedge clk);
        if (spurious) begin
            chk("busy_on_spurious", 128'(busy), 128'(1));
            req_addr = addr ^ 32'h0000_5000; req_rw = ~rw; req_data = ~data;
            @(negedge clk);
        end
        req_valid = 1'b0;
        n = 0;
        while (resp_seen < target && n < 300) begin @(negedge clk); n++; end
        if (resp_seen < target) begin
            checks++; errors++;
            $display("FAIL resp_timeout: got %0d responses, expected %0d", resp_seen, target);
            do_reset();
        end
    endtask

    initial begin
        int unsigned n;
        logic [ADDR_W-1:0] a;
        logic [7:0] idx;
        repeat (2) @(negedge clk);
        do_reset();

        // Cold read miss, then a hit on the same block.
        dram[32'h0000_1040] = {32{4'hA}};
        issue(1'b0, 32'h0000_1040, '0, 1'b0);
        issue(1'b0, 32'h0000_1040, '0, 1'b0);

        // Dirty the block, then push it out of set 4.
        issue(1'b1, 32'h0000_1040, 128'h1234, 1'b0);
        for (int unsigned t = 2; t <= 5; t++) issue(1'b0, (t << 12) | 32'h40, '0, 1'b0);

        // Re-reading T0 leaves way 1 oldest; it is clean so no write-back.
        do_reset();
        for (int unsigned t = 6; t <= 9; t++) issue(1'b0, (t << 12) | 32'h40, '0, 1'b0);
        issue(1'b0, 32'h0000_6040, '0, 1'b0);
        issue(1'b0, 32'h0000_A040, '0, 1'b0);

        // Reset while waiting on a refill; the late completion must be ignored.
        auto_mem = 1'b0;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h0000_3090;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(mreq_valid && !mreq_rw) && n < 20) begin @(negedge clk); n++; end
        chk("alloc_reached", 128'(mreq_valid && !mreq_rw), 128'(1));
        do_reset();
        mres_ready = 1'b1;
        mres_data  = {4{32'hdead_beef}};
        #1;
        chk("late_ready_dar_we", 128'(dar_we), 128'(0));
        @(negedge clk);
        mres_ready = 1'b0;
        chk("late_ready_busy", 128'(busy), 128'(0));
        chk("late_ready_mreq", 128'(mreq_valid), 128'(0));
        repeat (4) @(negedge clk);
        auto_mem = 1'b1;
        issue(1'b0, 32'h0000_3090, '0, 1'b0);

        // A request pulsed while busy is dropped.
        issue(1'b0, 32'h0002_0070, '0, 1'b1);
        issue(1'b1, 32'h0002_0070, 128'h5555, 1'b1);

        for (int unsigned i = 0; i < 300; i++) begin
            n   = $urandom_range(0, 2);
            idx = (n == 0) ? 8'd4 : (n == 1) ? 8'd5 : 8'd200;
            a   = ($urandom_range(0, 7) << 12) | (32'(idx) << 4) | $urandom_range(0, 15);
            issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom},
                  ($urandom_range(0, 7) == 0));
        end

        repeat (5) @(negedge clk);
        chk("resp_queue_drained", 128'(exp_q.size()), 128'(0));
        chk("mem_queue_drained", 128'(mq.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion within time limit, expected $finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end
endmodule
